// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int c_max_w = 64;

    // Quotient reported for a zero divisor; sliced to the dividend width at use.
    localparam logic [c_max_w-1:0] c_div0_quot = '1;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_sign_conv.sv
`default_nettype none
// ============================================================================
//  Module      : div_sign_conv
//  Description : Conditional two's-complement negate (pass-through if unsigned).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_sign_conv #(
    parameter int W      = 32,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0] i_data,
    input  logic         i_neg,
    output logic [W-1:0] o_data
);

    generate
        if (SIGNED != 0) begin : g_signed
            assign o_data = i_neg ? (~i_data + W'(1)) : i_data;
        end else begin : g_unsigned
            logic w_unused_neg;
            assign w_unused_neg = i_neg;
            assign o_data       = i_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/divider_iterative.sv
`default_nettype none
// ============================================================================
//  Module      : divider_iterative
//  Description : Radix-2 restoring divider, sign-magnitude around unsigned core.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_iterative
    import div_pkg::*;
#(
    parameter int SIGNED     = 0,
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_en_ff,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DIVIDEND_W-1:0] o_quot,
    output logic [DIVISOR_W-1:0]  o_rem,
    output logic                  o_div0
);

    localparam int                    c_cnt_w     = cnt_width(DIVIDEND_W);
    localparam logic [c_cnt_w-1:0]    c_cnt_init  = c_cnt_w'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] c_quot_div0 = c_div0_quot[DIVIDEND_W-1:0];

    div_state_e            r_state;
    div_state_e            w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [DIVIDEND_W-1:0] r_dvd;      // dividend bits shift out of MSB, quotient bits enter at LSB
    logic [DIVISOR_W-1:0]  r_dsr;
    logic [DIVISOR_W-1:0]  r_prem;     // always < divisor, so the DIVISOR_W+1 bit only exists after the shift
    logic                  r_q_neg;
    logic                  r_r_neg;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_div0;

    logic                  w_dvd_neg;
    logic                  w_dsr_neg;
    logic                  w_dsr_zero;
    logic                  w_accept;
    logic [DIVIDEND_W-1:0] w_dvd_abs;
    logic [DIVISOR_W-1:0]  w_dsr_abs;
    logic [DIVISOR_W:0]    w_shift;
    logic [DIVISOR_W+1:0]  w_trial;
    logic                  w_qbit;
    logic [DIVISOR_W-1:0]  w_prem_nxt;
    logic [DIVIDEND_W-1:0] w_quot_mag;
    logic [DIVIDEND_W-1:0] w_quot_fix;
    logic [DIVISOR_W-1:0]  w_rem_fix;
    logic                  w_unused_trial;

    assign w_dvd_neg  = (SIGNED != 0) && i_dividend[DIVIDEND_W-1];
    assign w_dsr_neg  = (SIGNED != 0) && i_divisor[DIVISOR_W-1];
    assign w_dsr_zero = (i_divisor == '0);

    assign o_ready  = (r_state == IDLE) && i_en_ff;
    assign o_valid  = (r_state == DONE);
    assign w_accept = i_valid && o_ready;

    div_sign_conv #(.W(DIVIDEND_W), .SIGNED(SIGNED)) u_abs_dvd (
        .i_data (i_dividend),
        .i_neg  (w_dvd_neg),
        .o_data (w_dvd_abs)
    );

    div_sign_conv #(.W(DIVISOR_W), .SIGNED(SIGNED)) u_abs_dsr (
        .i_data (i_divisor),
        .i_neg  (w_dsr_neg),
        .o_data (w_dsr_abs)
    );

    // One restoring step: shift in the next dividend bit, trial-subtract.
    assign w_shift        = {r_prem, r_dvd[DIVIDEND_W-1]};
    assign w_trial        = {1'b0, w_shift} - {2'b00, r_dsr};
    assign w_qbit         = ~w_trial[DIVISOR_W+1];
    assign w_prem_nxt     = w_qbit ? w_trial[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];
    assign w_quot_mag     = {r_dvd[DIVIDEND_W-2:0], w_qbit};
    assign w_unused_trial = w_trial[DIVISOR_W];

    div_sign_conv #(.W(DIVIDEND_W), .SIGNED(SIGNED)) u_fix_quot (
        .i_data (w_quot_mag),
        .i_neg  (r_q_neg),
        .o_data (w_quot_fix)
    );

    div_sign_conv #(.W(DIVISOR_W), .SIGNED(SIGNED)) u_fix_rem (
        .i_data (w_prem_nxt),
        .i_neg  (r_r_neg),
        .o_data (w_rem_fix)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else if (i_en_ff) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_dsr_zero ? DONE : CALC;
            CALC:    if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    if (i_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result registers are only written on entry to DONE so they hold otherwise.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_prem  <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_div0  <= 1'b0;
        end else if (i_en_ff) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dvd   <= w_dvd_abs;
                        r_dsr   <= w_dsr_abs;
                        r_prem  <= '0;
                        r_cnt   <= c_cnt_init;
                        r_q_neg <= w_dvd_neg ^ w_dsr_neg;
                        r_r_neg <= w_dvd_neg;
                        if (w_dsr_zero) begin
                            r_quot <= c_quot_div0;
                            r_rem  <= i_dividend[DIVISOR_W-1:0];
                            r_div0 <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_prem <= w_prem_nxt;
                    r_dvd  <= w_quot_mag;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_quot <= w_quot_fix;
                        r_rem  <= w_rem_fix;
                        r_div0 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_div0 = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_divider_iterative.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_iterative
//  Description : Self-checking bench, unsigned and signed instances share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_iterative;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        valid_in;
    logic        rdy;
    logic [31:0] dividend;
    logic [15:0] divisor;

    logic        ready_u, valid_u, div0_u;
    logic [31:0] quot_u;
    logic [15:0] rem_u;
    logic        ready_s, valid_s, div0_s;
    logic [31:0] quot_s;
    logic [15:0] rem_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    divider_iterative #(.SIGNED(0), .DIVIDEND_W(32), .DIVISOR_W(16)) u_dut_u (
        .i_clk (clk), .i_rstn (rstn), .i_en_ff (en),
        .i_valid (valid_in), .o_ready (ready_u),
        .i_dividend (dividend), .i_divisor (divisor),
        .o_valid (valid_u), .i_ready (rdy),
        .o_quot (quot_u), .o_rem (rem_u), .o_div0 (div0_u)
    );

    divider_iterative #(.SIGNED(1), .DIVIDEND_W(32), .DIVISOR_W(16)) u_dut_s (
        .i_clk (clk), .i_rstn (rstn), .i_en_ff (en),
        .i_valid (valid_in), .o_ready (ready_s),
        .i_dividend (dividend), .i_divisor (divisor),
        .o_valid (valid_s), .i_ready (rdy),
        .o_quot (quot_s), .o_rem (rem_s), .o_div0 (div0_s)
    );

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q_u;
        logic [15:0] r_u;
        logic        d_u;
        logic [31:0] q_s;
        logic [15:0] r_s;
        logic        d_s;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Truncating division from plain integer arithmetic.
    function automatic void model(input logic [31:0] a, input logic [15:0] b, input bit sgn,
                                  output logic [31:0] q, output logic [15:0] r, output logic d);
        longint sa, sb, lq, lr;
        if (b == 16'h0) begin
            q = 32'hFFFF_FFFF;
            r = a[15:0];
            d = 1'b1;
        end else begin
            if (sgn) begin
                sa = $signed(a);
                sb = $signed(b);
            end else begin
                sa = {32'h0, a};
                sb = {48'h0, b};
            end
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[15:0];
            d  = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [15:0] b);
        int g;
        dividend = a;
        divisor  = b;
        valid_in = 1'b1;
        g = 0;
        while (!ready_u && g < 100) begin
            step();
            g++;
        end
        if (!ready_u) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: got ready=%b expected 1", ready_u);
        end
        step();
        valid_in = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!valid_u && lat < 200) begin
            step();
            lat++;
        end
        if (!valid_u) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got valid=%b expected 1", valid_u);
        end
    endtask

    task automatic chk_res(input string tag, input logic [31:0] qu, input logic [15:0] ru, input logic du,
                           input logic [31:0] qs, input logic [15:0] rs, input logic ds);
        chk({tag, "_quot_u"}, quot_u, qu);
        chk({tag, "_rem_u"},  {16'h0, rem_u}, {16'h0, ru});
        chk({tag, "_div0_u"}, {31'h0, div0_u}, {31'h0, du});
        chk({tag, "_valid_s"}, {31'h0, valid_s}, 32'h1);
        chk({tag, "_quot_s"}, quot_s, qs);
        chk({tag, "_rem_s"},  {16'h0, rem_s}, {16'h0, rs});
        chk({tag, "_div0_s"}, {31'h0, div0_s}, {31'h0, ds});
    endtask

    initial begin
        int lat;
        logic [31:0] a, eq_u, eq_s;
        logic [15:0] b, er_u, er_s;
        logic ed_u, ed_s, acc, got, fin;
        int guard;

        vecs[0] = '{32'd100,       16'd7,      32'd14,        16'd2,      1'b0, 32'd14,        16'd2,      1'b0, 33};
        vecs[1] = '{32'hFFFF_FF9C, 16'd7,      32'h2492_4916, 16'd2,      1'b0, 32'hFFFF_FFF2, 16'hFFFE,   1'b0, 33};
        vecs[2] = '{32'd100,       16'hFFF9,   32'd0,         16'd100,    1'b0, 32'hFFFF_FFF2, 16'd2,      1'b0, 33};
        vecs[3] = '{32'hFFFF_FF9C, 16'hFFF9,   32'h0001_0006, 16'hFFC6,   1'b0, 32'd14,        16'hFFFE,   1'b0, 33};
        vecs[4] = '{32'h1234_5678, 16'd0,      32'hFFFF_FFFF, 16'h5678,   1'b1, 32'hFFFF_FFFF, 16'h5678,   1'b1, 1};
        vecs[5] = '{32'h8000_0000, 16'hFFFF,   32'h0000_8000, 16'h8000,   1'b0, 32'h8000_0000, 16'd0,      1'b0, 33};
        vecs[6] = '{32'd0,         16'd5,      32'd0,         16'd0,      1'b0, 32'd0,         16'd0,      1'b0, 33};
        vecs[7] = '{32'hFFFF_FFFF, 16'd1,      32'hFFFF_FFFF, 16'd0,      1'b0, 32'hFFFF_FFFF, 16'd0,      1'b0, 33};
        vecs[8] = '{32'd7,         16'd100,    32'd0,         16'd7,      1'b0, 32'd0,         16'd7,      1'b0, 33};

        rstn = 1'b0; en = 1'b1; valid_in = 1'b0; rdy = 1'b1;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_u", {31'h0, ready_u}, 32'h1);
        chk("rst_valid_u", {31'h0, valid_u}, 32'h0);
        chk("rst_quot_u",  quot_u, 32'h0);
        chk("rst_rem_u",   {16'h0, rem_u}, 32'h0);
        chk("rst_div0_u",  {31'h0, div0_u}, 32'h0);
        chk("rst_ready_s", {31'h0, ready_s}, 32'h1);
        chk("rst_valid_s", {31'h0, valid_s}, 32'h0);
        rstn = 1'b1;
        step();

        // Directed table, including divide-by-zero and MIN / -1
        for (int i = 0; i < 9; i++) begin
            rdy = 1'b1;
            issue(vecs[i].a, vecs[i].b);
            wait_done(lat);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk_res($sformatf("vec%0d", i), vecs[i].q_u, vecs[i].r_u, vecs[i].d_u,
                    vecs[i].q_s, vecs[i].r_s, vecs[i].d_s);
        end
        step();

        // Backpressure: results held, new operands ignored
        rdy = 1'b0;
        issue(32'd100, 16'd7);
        wait_done(lat);
        dividend = 32'd9; divisor = 16'd3; valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", {31'h0, valid_u}, 32'h1);
            chk("bp_ready", {31'h0, ready_u}, 32'h0);
            chk("bp_quot",  quot_u, 32'd14);
            chk("bp_rem",   {16'h0, rem_u}, 32'd2);
        end
        valid_in = 1'b0;
        rdy = 1'b1;
        step();
        chk("bp_release_ready", {31'h0, ready_u}, 32'h1);
        chk("bp_release_valid", {31'h0, valid_u}, 32'h0);
        chk("bp_hold_quot",     quot_u, 32'd14);
        chk("bp_hold_rem",      {16'h0, rem_u}, 32'd2);

        // Stall five cycles mid-CALC
        issue(32'd100, 16'd7);
        lat = 1;
        while (!valid_u && lat < 200) begin
            en = !(lat >= 10 && lat < 15);
            #1;
            if (!en) chk("stall_ready", {31'h0, ready_u}, 32'h0);
            step();
            lat++;
        end
        en = 1'b1;
        chk("stall_latency", lat, 38);
        chk_res("stall", 32'd14, 16'd2, 1'b0, 32'd14, 16'd2, 1'b0);
        step();

        // Asynchronous reset mid-CALC
        issue(32'd100, 16'd7);
        repeat (10) step();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid_u", {31'h0, valid_u}, 32'h0);
        chk("arst_ready_u", {31'h0, ready_u}, 32'h1);
        chk("arst_quot_u",  quot_u, 32'h0);
        chk("arst_valid_s", {31'h0, valid_s}, 32'h0);
        chk("arst_ready_s", {31'h0, ready_s}, 32'h1);
        step();
        rstn = 1'b1;
        issue(32'd1000, 16'd3);
        wait_done(lat);
        chk_res("post_rst", 32'd333, 16'd1, 1'b0, 32'd333, 16'd1, 1'b0);
        step();

        // Randomized operands with random enable / output backpressure
        for (int n = 0; n < 800; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 16'h0;
                1:       b = 16'hFFFF;
                2:       b = 16'(  $urandom_range(1, 15));
                3:       b = 16'h8000;
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            model(a, b, 1'b0, eq_u, er_u, ed_u);
            model(a, b, 1'b1, eq_s, er_s, ed_s);
            dividend = a; divisor = b; valid_in = 1'b1;
            acc = 1'b0; guard = 0;
            while (!acc && guard < 200) begin
                en = ($urandom_range(0, 3) != 0);
                #1;
                acc = ready_u;
                step();
                guard++;
            end
            valid_in = 1'b0;
            got = 1'b0; fin = 1'b0; guard = 0;
            while (!fin && guard < 500) begin
                en  = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 2) != 0);
                #1;
                if (valid_u && !got) begin
                    chk_res("rand", eq_u, er_u, ed_u, eq_s, er_s, ed_s);
                    got = 1'b1;
                end
                if (valid_u && en && rdy) fin = 1'b1;
                step();
                guard++;
            end
            if (!fin) begin
                n_checks++;
                n_errors++;
                $display("FAIL rand_timeout: got valid=%b expected handshake", valid_u);
            end
        end
        en = 1'b1;
        rdy = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
